mac_sequencer: RTL and testbench
================================

MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter BIT_WIDTH, 32, float size in bits.
REQ-002 Parameter EXTRA_BITS, 2, FloPoCo exception bits, 0 or 2 only.
REQ-003 Parameter LEN_W, 8, width of the vector-length and neuron-count fields.
REQ-004 Parameter WADDR_W, 16, weight ROM address width.
REQ-005 CLK  in  1  single clock, all state on posedge.
REQ-006 RESET_N  in  1  asynchronous, active-low reset.
REQ-007 START  in  1  one-cycle pulse that launches a layer, sampled only in IDLE.
REQ-008 ABORT  in  1  cancels the layer in progress.
REQ-009 NUM_IN  in  LEN_W  input vector length, latched on accepted START.
REQ-010 NUM_OUT  in  LEN_W  neuron count, latched on accepted START.
REQ-011 WROM_ADDR / WROM_EN  out  WADDR_W / 1  weight ROM read address and enable; ROM data arrives 1 cycle later.
REQ-012 IN_ADDR / IN_EN  out  LEN_W / 1  input buffer read address and enable; data arrives 1 cycle later.
REQ-013 ACC_EN  out  1  to ALU: accumulate when high, start a fresh sum when low.
REQ-014 ALU_RESET  out  1  to ALU: synchronous active-high accumulator clear.
REQ-015 ACC_RESULT  in  BIT_WIDTH+EXTRA_BITS  registered MAC output from the ALU.
REQ-016 RESULT_DATA / RESULT_IDX / RESULT_VALID  out  BIT_WIDTH+EXTRA_BITS / LEN_W / 1  neuron result, neuron index, valid flag.
REQ-017 RESULT_READY  in  1  downstream accepts the result when high with RESULT_VALID.
REQ-018 BUSY / DONE  out  1 / 1  layer in progress; one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, DRAIN, OUTPUT, with transitions as follows.
- IDLE->ISSUE on START when NUM_IN>0 and NUM_OUT>0.
- ISSUE->DRAIN after NUM_IN element issues.
- DRAIN->OUTPUT after 2 cycles.
- OUTPUT->ISSUE on handshake while neurons remain; OUTPUT->IDLE on handshake for the last neuron.
REQ-020 In ISSUE, cycle k (k=0..NUM_IN-1) of neuron j SHALL assert WROM_EN and IN_EN with WROM_ADDR=j*NUM_IN+k and IN_ADDR=k.
- WROM_ADDR comes from a running counter; no multiplier.
REQ-021 The controller SHALL issue ACC_EN one cycle after each issue (aligned with the returned data): low for k=0, high for k>0, low when no element is in flight.
REQ-022 The controller SHALL capture ACC_RESULT into RESULT_DATA two cycles after the last issue of a neuron.
- Per-neuron latency from first issue to RESULT_VALID SHALL be NUM_IN+3 cycles.
REQ-023 RESULT_VALID, RESULT_DATA and RESULT_IDX SHALL be held stable in OUTPUT until RESULT_READY is high; a handshake SHALL occur only when RESULT_VALID && RESULT_READY.
REQ-024 DONE SHALL pulse for 1 cycle, in the cycle after the last handshake; BUSY SHALL be high in every state except IDLE.
REQ-025 START in IDLE with NUM_IN=0 or NUM_OUT=0 SHALL produce a DONE pulse on the next cycle, with no ROM or buffer reads and no results.
REQ-026 START outside IDLE SHALL be ignored.
- NUM_IN and NUM_OUT changes after acceptance SHALL have no effect.
REQ-027 ABORT in any non-IDLE state SHALL force IDLE on the next edge; there SHALL be no DONE pulse, and RESULT_VALID SHALL drop.
- ABORT has priority over RESULT_READY in the same cycle.
REQ-028 ALU_RESET SHALL be high in IDLE and low in every other state.
REQ-029 The element counter SHALL wrap to 0 at the end of each neuron; the neuron counter SHALL wrap to 0 on exit to IDLE.
- WROM_ADDR SHALL wrap modulo 2^WADDR_W.

Reset
REQ-030 With RESET_N low, the FSM SHALL be in IDLE and all counters SHALL be 0.
REQ-031 With RESET_N low, outputs SHALL be as follows.
- 0: WROM_ADDR, WROM_EN, IN_ADDR, IN_EN, ACC_EN, RESULT_DATA, RESULT_IDX, RESULT_VALID, BUSY, DONE.
- 1: ALU_RESET.
REQ-032 Reset assertion mid-layer SHALL abandon the layer immediately, with no DONE pulse.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, the FloPoCo exception-code constants, and the LEN_W/WADDR_W defaults.
REQ-034 One sub-module, mac_issue_counter, SHALL hold the element index, the neuron index and the running WROM_ADDR counter.

Verification
REQ-035 NUM_IN=3, NUM_OUT=2, all weights and inputs FloPoCo 1.0, RESULT_READY tied high -> two results of 3.0 with IDX 0 then 1, each 6 cycles after its first issue, then DONE.
REQ-036 NUM_IN=4, NUM_OUT=1 -> WROM_ADDR 0,1,2,3 in consecutive cycles and ACC_EN sequence 0,1,1,1.
REQ-037 RESULT_READY held low 5 cycles in OUTPUT -> RESULT_DATA/IDX stable for those cycles, no new issues, resume after the handshake.
REQ-038 ABORT in the second ISSUE cycle -> IDLE next cycle, BUSY=0, no DONE, no RESULT_VALID.
REQ-039 START with NUM_OUT=0 -> DONE next cycle, WROM_EN never asserted; START while BUSY -> ignored.
REQ-040 RESET_N low mid-DRAIN -> all outputs at reset values asynchronously, ALU_RESET=1.

Source files
------------

// File: rtl/mac_sequencer_pkg.sv
// Shared types and constants for the MAC sequencer and its issue counter.
// FloPoCo floats carry a 2-bit exception tag above the IEEE-style payload.
package mac_sequencer_pkg;

    localparam int LEN_W_DEF   = 8;
    localparam int WADDR_W_DEF = 16;

    localparam logic [1:0] FP_EXC_ZERO   = 2'b00;
    localparam logic [1:0] FP_EXC_NORMAL = 2'b01;
    localparam logic [1:0] FP_EXC_INF    = 2'b10;
    localparam logic [1:0] FP_EXC_NAN    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_OUTPUT = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mac_issue_counter.sv
// Element, neuron and running weight-address counters for the sequencer.
// The weight address advances by one per issue, so no multiplier is needed.
module mac_issue_counter
    import mac_sequencer_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int WADDR_W = WADDR_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clr,
    input  logic               i_step,
    input  logic               i_next,
    input  logic [LEN_W-1:0]   i_num_in,
    input  logic [LEN_W-1:0]   i_num_out,
    output logic [LEN_W-1:0]   o_elem,
    output logic [LEN_W-1:0]   o_neuron,
    output logic [WADDR_W-1:0] o_addr,
    output logic               o_last_elem,
    output logic               o_last_neuron
);

    logic [LEN_W-1:0]   r_elem;
    logic [LEN_W-1:0]   r_neuron;
    logic [WADDR_W-1:0] r_addr;
    logic               w_last_elem;

    assign w_last_elem = (r_elem == i_num_in - 1'b1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_elem   <= '0;
            r_neuron <= '0;
            r_addr   <= '0;
        end else if (i_clr) begin
            r_elem   <= '0;
            r_neuron <= '0;
            r_addr   <= '0;
        end else begin
            if (i_step) begin
                r_addr <= r_addr + 1'b1;
                r_elem <= w_last_elem ? '0 : r_elem + 1'b1;
            end
            if (i_next) begin
                r_neuron <= r_neuron + 1'b1;
            end
        end
    end

    assign o_elem        = r_elem;
    assign o_neuron      = r_neuron;
    assign o_addr        = r_addr;
    assign o_last_elem   = w_last_elem;
    assign o_last_neuron = (r_neuron == i_num_out - 1'b1);

endmodule

// File: rtl/mac_sequencer.sv
// Layer sequencer: streams weight/input reads per neuron into a MAC ALU,
// then presents each neuron result on a valid/ready handshake.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int EXTRA_BITS = 2,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int WADDR_W    = WADDR_W_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [LEN_W-1:0]              i_num_in,
    input  logic [LEN_W-1:0]              i_num_out,
    output logic [WADDR_W-1:0]            o_wrom_addr,
    output logic                          o_wrom_en,
    output logic [LEN_W-1:0]              o_in_addr,
    output logic                          o_in_en,
    output logic                          o_acc_en,
    output logic                          o_alu_reset,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0] i_acc_result,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0] o_result_data,
    output logic [LEN_W-1:0]              o_result_idx,
    output logic                          o_result_valid,
    input  logic                          i_result_ready,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int DW = BIT_WIDTH + EXTRA_BITS;

    seq_state_e         r_state;
    seq_state_e         w_next;
    logic [LEN_W-1:0]   r_num_in;
    logic [LEN_W-1:0]   r_num_out;
    logic               r_drain;
    logic               r_acc_en;
    logic               r_done;
    logic [DW-1:0]      r_data;
    logic [LEN_W-1:0]   r_idx;

    logic               w_start_ok;
    logic               w_issue;
    logic               w_hs;
    logic               w_clr;
    logic [LEN_W-1:0]   w_elem;
    logic [LEN_W-1:0]   w_neuron;
    logic [WADDR_W-1:0] w_addr;
    logic               w_last_elem;
    logic               w_last_neuron;

    assign w_start_ok = i_start && (i_num_in != '0) && (i_num_out != '0);
    assign w_issue    = (r_state == S_ISSUE);
    assign w_hs       = (r_state == S_OUTPUT) && i_result_ready;
    assign w_clr      = (w_next == S_IDLE);

    mac_issue_counter #(
        .LEN_W   (LEN_W),
        .WADDR_W (WADDR_W)
    ) u_cnt (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_clr         (w_clr),
        .i_step        (w_issue),
        .i_next        (w_hs),
        .i_num_in      (r_num_in),
        .i_num_out     (r_num_out),
        .o_elem        (w_elem),
        .o_neuron      (w_neuron),
        .o_addr        (w_addr),
        .o_last_elem   (w_last_elem),
        .o_last_neuron (w_last_neuron)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_start_ok) w_next = S_ISSUE;
            S_ISSUE:  if (w_last_elem) w_next = S_DRAIN;
            S_DRAIN:  if (r_drain) w_next = S_OUTPUT;
            S_OUTPUT: begin
                if (i_result_ready) begin
                    w_next = w_last_neuron ? S_IDLE : S_ISSUE;
                end
            end
            default:  w_next = S_IDLE;
        endcase
        // Abort outranks a same-cycle handshake
        if (i_abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num_in  <= '0;
            r_num_out <= '0;
            r_drain   <= 1'b0;
            r_acc_en  <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= '0;
            r_idx     <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_num_in  <= i_num_in;
                r_num_out <= i_num_out;
            end
            r_drain  <= (r_state == S_DRAIN) && !r_drain;
            r_acc_en <= w_issue && !i_abort && (w_elem != '0);
            r_done   <= ((r_state == S_IDLE) && i_start && !w_start_ok)
                     || (w_hs && w_last_neuron && !i_abort);
            // ALU sum of the neuron settles by the second drain cycle
            if ((r_state == S_DRAIN) && r_drain) begin
                r_data <= i_acc_result;
                r_idx  <= w_neuron;
            end
        end
    end

    assign o_wrom_addr    = w_addr;
    assign o_wrom_en      = w_issue;
    assign o_in_addr      = w_elem;
    assign o_in_en        = w_issue;
    assign o_acc_en       = r_acc_en;
    assign o_alu_reset    = (r_state == S_IDLE);
    assign o_result_data  = r_data;
    assign o_result_idx   = r_idx;
    assign o_result_valid = (r_state == S_OUTPUT);
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: ROM, input buffer and MAC ALU
// are modelled with integer values encoded as FloPoCo floats.
module tb_mac_sequencer;

    localparam int DW = 34;
    localparam int LW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b1;
    logic [LW-1:0] num_in = '0;
    logic [LW-1:0] num_out = '0;
    logic [AW-1:0] wrom_addr;
    logic          wrom_en;
    logic [LW-1:0] in_addr;
    logic          in_en;
    logic          acc_en;
    logic          alu_reset;
    logic [DW-1:0] acc_result;
    logic [DW-1:0] rdata;
    logic [LW-1:0] ridx;
    logic          valid;
    logic          busy;
    logic          done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int g_mode = 0;
    int g_seed = 3;

    always #5 clk = ~clk;

    mac_sequencer #(
        .BIT_WIDTH  (32),
        .EXTRA_BITS (2),
        .LEN_W      (LW),
        .WADDR_W    (AW)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_num_in       (num_in),
        .i_num_out      (num_out),
        .o_wrom_addr    (wrom_addr),
        .o_wrom_en      (wrom_en),
        .o_in_addr      (in_addr),
        .o_in_en        (in_en),
        .o_acc_en       (acc_en),
        .o_alu_reset    (alu_reset),
        .i_acc_result   (acc_result),
        .o_result_data  (rdata),
        .o_result_idx   (ridx),
        .o_result_valid (valid),
        .i_result_ready (ready),
        .o_busy         (busy),
        .o_done         (done)
    );

    // Exact FloPoCo encoding of a small non-negative integer
    function automatic logic [DW-1:0] to_fp(input int unsigned n);
        int p;
        logic [31:0] f;
        if (n == 0) return '0;
        p = 31;
        while (n[p] == 1'b0) p--;
        f = {1'b0, 8'(127 + p), 23'(n << (23 - p))};
        return {2'b01, f};
    endfunction

    function automatic int unsigned wval(input int a);
        return (g_mode == 1) ? 1 : (a * 7 + g_seed) % 13;
    endfunction

    function automatic int unsigned ival(input int k);
        return (g_mode == 1) ? 1 : (k * 5 + g_seed) % 11;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // ROM / buffer with one-cycle read latency feeding an integer MAC
    logic        dv = 1'b0;
    int unsigned pw = 0;
    int unsigned px = 0;
    int unsigned acc = 0;

    always @(posedge clk) begin
        dv <= wrom_en;
        pw <= wval(int'(wrom_addr));
        px <= in_en ? ival(int'(in_addr)) : 0;
        if (alu_reset) acc <= 0;
        else if (dv) acc <= acc_en ? acc + pw * px : pw * px;
    end

    assign acc_result = to_fp(acc);

    // Reference model: expected issue stream, results and handshake flags
    int          iss_a[$];
    int          iss_k[$];
    logic [DW-1:0] res_d[$];
    int          res_i[$];
    int          nin = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_out = 0;
    bit          m_exp_iss = 0;
    bit          m_prev_iss = 0;
    bit          m_prev_k0 = 1;
    int          m_due = -1;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            iss_a.delete(); iss_k.delete();
            res_d.delete(); res_i.delete();
            m_busy = 0; m_done = 0; m_out = 0; m_exp_iss = 0;
            m_prev_iss = 0; m_prev_k0 = 1; m_due = -1;
        end else begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("alu_reset", alu_reset, !m_busy);
            chk("in_en", in_en, wrom_en);
            chk("acc_en", acc_en, m_prev_iss && !m_prev_k0);
            if (m_exp_iss) chk("issue_start", wrom_en, 1);
            if (m_due == cyc) m_out = 1;
            chk("valid", valid, m_out);
            if (m_out) begin
                chk("no_issue_in_output", wrom_en, 0);
                chk("res_data", rdata, res_d[0]);
                chk("res_idx", ridx, res_i[0]);
            end
            if (wrom_en) begin
                if (iss_a.size() == 0) begin
                    chk("spurious_issue", wrom_en, 0);
                    m_prev_k0 = 1;
                end else begin
                    chk("wrom_addr", wrom_addr, iss_a[0]);
                    chk("in_addr", in_addr, iss_k[0]);
                    if (iss_k[0] == nin - 1) m_due = cyc + 3;
                    m_prev_k0 = (iss_k[0] == 0);
                    void'(iss_a.pop_front());
                    void'(iss_k.pop_front());
                end
            end
            m_prev_iss = wrom_en && !abort;
            m_done = 0;
            m_exp_iss = 0;
            if (m_busy && abort) begin
                m_busy = 0; m_out = 0; m_due = -1;
                iss_a.delete(); iss_k.delete();
                res_d.delete(); res_i.delete();
            end else if (m_busy && m_out && ready) begin
                void'(res_d.pop_front());
                void'(res_i.pop_front());
                m_out = 0; m_due = -1;
                if (res_d.size() == 0) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_exp_iss = 1;
                end
            end else if (!m_busy && start) begin
                if (num_in != 0 && num_out != 0) begin
                    nin = int'(num_in);
                    for (int j = 0; j < int'(num_out); j++) begin
                        int unsigned s;
                        s = 0;
                        for (int k = 0; k < nin; k++) begin
                            int a;
                            a = (j * nin + k) % (1 << AW);
                            iss_a.push_back(a);
                            iss_k.push_back(k);
                            s += wval(a) * ival(k);
                        end
                        res_d.push_back(to_fp(s));
                        res_i.push_back(j);
                    end
                    m_busy = 1;
                    m_exp_iss = 1;
                end else begin
                    m_done = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int ni, input int no);
        num_in = LW'(ni);
        num_out = LW'(no);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        int c;
        c = 0;
        while (busy && c < lim) begin
            tick();
            c++;
        end
        chk("idle_timeout", busy, 0);
        tick();
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int c;
        c = 1;
        while (!valid && c < 40) begin
            tick();
            c++;
        end
        chk(name, c, exp_lat);
    endtask

    task automatic chk_reset_outs();
        chk("rst_wrom_addr", wrom_addr, 0);
        chk("rst_wrom_en", wrom_en, 0);
        chk("rst_in_addr", in_addr, 0);
        chk("rst_in_en", in_en, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_data", rdata, 0);
        chk("rst_idx", ridx, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_alu_reset", alu_reset, 1);
    endtask

    initial begin
        logic [AW-1:0] a_seq [5];
        logic [4:0]    e_seq;
        logic [DW-1:0] hold_d;
        logic [LW-1:0] hold_i;

        repeat (3) tick();
        chk_reset_outs();
        rst_n = 1'b1;
        tick();

        // Two neurons of three 1.0*1.0 products each
        g_mode = 1;
        ready = 1'b1;
        launch(3, 2);
        wait_valid("lat_n0", 6);
        chk("n0_data", rdata, 34'h1_4040_0000);
        chk("n0_idx", ridx, 0);
        tick();
        wait_valid("lat_n1", 6);
        chk("n1_data", rdata, 34'h1_4040_0000);
        chk("n1_idx", ridx, 1);
        tick();
        chk("n1_done", done, 1);
        tick();
        chk("n1_done_len", done, 0);

        // Address and accumulate-enable sequence
        g_mode = 0;
        launch(4, 1);
        for (int i = 0; i < 5; i++) begin
            a_seq[i] = wrom_addr;
            e_seq[i] = acc_en;
            tick();
        end
        for (int i = 0; i < 4; i++) chk("addr_seq", a_seq[i], i);
        chk("acc_en_seq", e_seq[4:1], 4'b1110);
        wait_idle(50);

        // Backpressure: result held while ready is low
        ready = 1'b0;
        launch(2, 2);
        wait_valid("bp_lat", 5);
        hold_d = rdata;
        hold_i = ridx;
        chk("bp_idx", hold_i, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", valid, 1);
            chk("bp_data_stable", rdata, hold_d);
            chk("bp_idx_stable", ridx, hold_i);
        end
        ready = 1'b1;
        wait_idle(50);

        // Abort during the second issue cycle
        launch(4, 2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", done, 0);
            chk("abort_no_valid", valid, 0);
            tick();
        end

        // Empty layer, then start while busy
        launch(3, 0);
        chk("empty_done", done, 1);
        chk("empty_no_rom", wrom_en, 0);
        tick();
        launch(3, 1);
        launch(5, 3);
        wait_idle(60);

        // Address wrap beyond the ROM size
        launch(40, 30);
        wait_idle(3000);

        // Reset asserted in the first drain cycle
        launch(3, 2);
        while (wrom_en) tick();
        chk("drain_reached", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            ready = ($urandom_range(0, 9) < 7);
            abort = ($urandom_range(0, 149) == 0);
            start = ($urandom_range(0, 7) == 0);
            num_in = LW'($urandom_range(0, 6));
            num_out = LW'($urandom_range(0, 4));
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        wait_idle(200);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
